contador_checker: RTL

- Synthesizable monitor for the 4-mode counter. It is the receiving end of the counter stimulus interface.
- It samples the same ENB/MODO/D that the tester drives into the counter, and keeps a cycle-accurate shadow model of the counter.
- It compares the counter's Q/RCO against that model on every clock edge and reports mismatches.
- It sits beside the counter DUT in the bench and in the 16-bit cascade, with one instance per 4-bit stage.

---
 rtl/contador_pkg.sv | 16 +
 rtl/contador_modelo.sv | 47 ++++
 rtl/contador_checker.sv | 83 ++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared encodings for the 4-mode counter and its checker.
package contador_pkg;

    typedef enum logic [1:0] {
        MODO_ARRIBA = 2'b00,
        MODO_ABAJO  = 2'b01,
        MODO_ABAJO3 = 2'b10,
        MODO_CARGA  = 2'b11
    } modo_e;

    typedef enum logic {
        UNSYNC = 1'b0,
        CHECK  = 1'b1
    } estado_e;

endpackage

// File: rtl/contador_modelo.sv
// Combinational next-value/carry function of the 4-mode counter.
module contador_modelo
    import contador_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] q,
    input  logic         enb,
    input  logic [1:0]   modo,
    input  logic [W-1:0] d,
    output logic [W-1:0] q_next,
    output logic         rco_next
);

    logic [W:0] suma;

    // Arithmetic in W+1 bits: bit W is the carry or borrow out of the stage.
    always_comb begin
        suma     = {1'b0, q};
        q_next   = q;
        rco_next = 1'b0;
        if (enb) begin
            case (modo_e'(modo))
                MODO_ARRIBA: begin
                    suma     = {1'b0, q} + (W+1)'(1);
                    q_next   = suma[W-1:0];
                    rco_next = suma[W];
                end
                MODO_ABAJO: begin
                    suma     = {1'b0, q} - (W+1)'(1);
                    q_next   = suma[W-1:0];
                    rco_next = suma[W];
                end
                MODO_ABAJO3: begin
                    suma     = {1'b0, q} - (W+1)'(3);
                    q_next   = suma[W-1:0];
                    rco_next = suma[W];
                end
                default: begin
                    q_next   = d;
                    rco_next = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/contador_checker.sv
// Shadow model of the 4-mode counter; compares DUT Q/RCO one edge after each stimulus.
module contador_checker
    import contador_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RESET_L,
    input  logic          ENB,
    input  logic [1:0]    MODO,
    input  logic [W-1:0]  D,
    input  logic [W-1:0]  Q,
    input  logic          RCO,
    output logic [W-1:0]  Q_ESP,
    output logic          RCO_ESP,
    output logic          SYNC,
    output logic          ERR,
    output logic          ERR_STICKY,
    output logic [CW-1:0] ERR_CNT,
    output logic [W-1:0]  Q_PRIMER_ERR
);

    estado_e      estado;
    logic         val;
    logic [W-1:0] q_next;
    logic         rco_next;
    logic         mismatch;

    contador_modelo #(.W(W)) u_modelo (
        .q        (Q_ESP),
        .enb      (ENB),
        .modo     (MODO),
        .d        (D),
        .q_next   (q_next),
        .rco_next (rco_next)
    );

    assign mismatch = (Q != Q_ESP) || (RCO != RCO_ESP);

    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            estado       <= UNSYNC;
            val          <= 1'b0;
            Q_ESP        <= '0;
            RCO_ESP      <= 1'b0;
            SYNC         <= 1'b0;
            ERR          <= 1'b0;
            ERR_STICKY   <= 1'b0;
            ERR_CNT      <= '0;
            Q_PRIMER_ERR <= '0;
        end else begin
            case (estado)
                UNSYNC: begin
                    ERR <= 1'b0;
                    if (ENB && (modo_e'(MODO) == MODO_CARGA)) begin
                        Q_ESP   <= q_next;
                        RCO_ESP <= rco_next;
                        SYNC    <= 1'b1;
                        val     <= 1'b1;
                        estado  <= CHECK;
                    end
                end
                CHECK: begin
                    ERR <= val && mismatch;
                    if (val && mismatch) begin
                        ERR_STICKY <= 1'b1;
                        if (ERR_CNT != '1)
                            ERR_CNT <= ERR_CNT + CW'(1);
                        if (!ERR_STICKY)
                            Q_PRIMER_ERR <= Q;
                    end
                    // The model follows the stimulus, never the DUT's Q.
                    Q_ESP   <= q_next;
                    RCO_ESP <= rco_next;
                    val     <= 1'b1;
                end
                default: estado <= UNSYNC;
            endcase
        end
    end

endmodule
